// File: rtl/uart_tx_arbiter.sv
// Two-requester byte arbiter feeding one 8N1 UART transmitter, with per-message locking.
// Optional lock timeout enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned CLKS_PER_BIT   = 868,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_in0_valid,
    input  logic [7:0] io_in0_bits,
    input  logic       io_in0_last,
    output logic       io_in0_ready,
    input  logic       io_in1_valid,
    input  logic [7:0] io_in1_bits,
    input  logic       io_in1_last,
    output logic       io_in1_ready,
    output logic       io_uart_tx,
    output logic       io_busy,
    output logic       io_owner
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    localparam logic [15:0] BaudMax = 16'(CLKS_PER_BIT - 1);

    state_e      r_state;
    state_e      w_state_next;
    logic [15:0] r_baud;
    logic [2:0]  r_bit;
    logic [7:0]  r_data;
    logic        r_last;
    logic        r_lock;
    logic        r_owner;

    logic        w_baud_done;
    logic        w_owner_valid;
    logic        w_grant;
    logic        w_sel;
    logic        w_timeout_clr;

    assign w_baud_done   = (r_baud == BaudMax);
    assign w_owner_valid = r_owner ? io_in1_valid : io_in0_valid;

    // While locked only the owner may be granted; otherwise ties go to the non-owner.
    always_comb begin
        w_grant = 1'b0;
        w_sel   = r_owner;
        if (r_state == StIdle) begin
            if (r_lock) begin
                w_grant = w_owner_valid;
                w_sel   = r_owner;
            end else if (io_in0_valid && io_in1_valid) begin
                w_grant = 1'b1;
                w_sel   = ~r_owner;
            end else if (io_in0_valid) begin
                w_grant = 1'b1;
                w_sel   = 1'b0;
            end else if (io_in1_valid) begin
                w_grant = 1'b1;
                w_sel   = 1'b1;
            end
        end
    end

    assign io_in0_ready = w_grant && !w_sel;
    assign io_in1_ready = w_grant && w_sel;
    assign io_busy      = (r_state != StIdle) || r_lock;
    assign io_owner     = r_owner;

    always_comb begin
        w_state_next = r_state;
        io_uart_tx   = 1'b1;
        unique case (r_state)
            StIdle: begin
                if (w_grant) w_state_next = StStart;
            end
            StStart: begin
                io_uart_tx = 1'b0;
                if (w_baud_done) w_state_next = StData;
            end
            StData: begin
                io_uart_tx = r_data[r_bit];
                if (w_baud_done && (r_bit == 3'd7)) w_state_next = StStop;
            end
            StStop: begin
                if (w_baud_done) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [31:0] ToMax = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] r_to_cnt;
    logic        w_to_run;

    assign w_to_run      = (r_state == StIdle) && r_lock && !w_owner_valid;
    assign w_timeout_clr = w_to_run && (r_to_cnt == ToMax);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (w_to_run && !w_timeout_clr) begin
            r_to_cnt <= r_to_cnt + 32'd1;
        end else begin
            r_to_cnt <= '0;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_timeout_clr    = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
            r_baud  <= '0;
            r_bit   <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_lock  <= 1'b0;
            r_owner <= 1'b1;
        end else begin
            r_state <= w_state_next;
            if ((r_state == StIdle) || w_baud_done) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 16'd1;
            end
            if ((r_state == StData) && w_baud_done) begin
                r_bit <= r_bit + 3'd1;
            end
            if (w_grant) begin
                r_data  <= w_sel ? io_in1_bits : io_in0_bits;
                r_last  <= w_sel ? io_in1_last : io_in0_last;
                r_owner <= w_sel;
            end
            // Lock follows the message boundary of the byte just finished.
            if ((r_state == StStop) && w_baud_done) begin
                r_lock <= ~r_last;
            end else if (w_timeout_clr) begin
                r_lock <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed sequences, random vs model.
module tb_uart_tx_arbiter;

    localparam int unsigned Cpb = 4;
    localparam int unsigned To  = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
    logic [7:0] b0 = 8'h00, b1 = 8'h00;
    logic       rdy0, rdy1, tx, busy, owner;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    uart_tx_arbiter #(
        .CLKS_PER_BIT  (Cpb),
        .TIMEOUT_CYCLES(To)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .io_in0_valid(v0),
        .io_in0_bits (b0),
        .io_in0_last (l0),
        .io_in0_ready(rdy0),
        .io_in1_valid(v1),
        .io_in1_bits (b1),
        .io_in1_last (l1),
        .io_in1_ready(rdy1),
        .io_uart_tx  (tx),
        .io_busy     (busy),
        .io_owner    (owner)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic v0;
        logic v1;
        logic r0;
        logic r1;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int unsigned j);
        logic [9:0] f;
        f = {1'b1, d, 1'b0} >> (j / Cpb);
        return f[0];
    endfunction

    // Returns at the negedge of the cycle in which a ready was seen.
    task automatic wait_grant(input int bound, output int who, output int waited);
        who    = -1;
        waited = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clock);
            if (rdy0 || rdy1) begin
                who    = (rdy0 && rdy1) ? 2 : (rdy1 ? 1 : 0);
                waited = k;
                return;
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_frame(input string name, input logic [7:0] d);
        int bad;
        bad = 0;
        for (int unsigned j = 0; j < 10 * Cpb; j++) begin
            @(negedge clock);
            if (tx !== frame_bit(d, j) || rdy0 || rdy1 || !busy) bad++;
        end
        chk(name, 32'(bad), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int who, waited, first, g;
        int unsigned m_free, m_start, m_to;
        logic m_lock, m_owner, m_pend, ov, e_r0, e_r1, e_tx, e_busy;
        logic [7:0] m_byte;

        tbl[0] = '{v0: 1'b0, v1: 1'b0, r0: 1'b0, r1: 1'b0};
        tbl[1] = '{v0: 1'b1, v1: 1'b0, r0: 1'b1, r1: 1'b0};
        tbl[2] = '{v0: 1'b0, v1: 1'b1, r0: 1'b0, r1: 1'b1};
        tbl[3] = '{v0: 1'b1, v1: 1'b1, r0: 1'b1, r1: 1'b0};

        // Reset state and first-grant arbitration, no clock edge in between.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            v0 = tbl[i].v0;
            v1 = tbl[i].v1;
            #1;
            chk($sformatf("vec%0d ready0", i), 32'(rdy0), 32'(tbl[i].r0));
            chk($sformatf("vec%0d ready1", i), 32'(rdy1), 32'(tbl[i].r1));
            chk($sformatf("vec%0d tx", i), 32'(tx), 32'd1);
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'd0);
            chk($sformatf("vec%0d owner", i), 32'(owner), 32'd1);
        end
        v0 = 1'b0;
        v1 = 1'b0;
        step();

        // Single 0x55 byte from in0.
        do_reset();
        v0 = 1'b1; b0 = 8'h55; l0 = 1'b1;
        wait_grant(8, who, waited);
        chk("0x55 grant", 32'(who), 32'd0);
        chk("0x55 latency", 32'(waited), 32'd0);
        step();
        v0 = 1'b0;
        check_frame("0x55 frame", 8'h55);
        step();
        @(negedge clock);
        chk("0x55 busy end", 32'(busy), 32'd0);
        chk("0x55 owner", 32'(owner), 32'd0);

        // Both held: alternate per message, back-to-back.
        do_reset();
        v0 = 1'b1; v1 = 1'b1; l0 = 1'b1; l1 = 1'b1; b0 = 8'h11; b1 = 8'h22;
        for (int f = 0; f < 4; f++) begin
            wait_grant(8, who, waited);
            chk($sformatf("rr%0d grant", f), 32'(who), 32'(f % 2));
            chk($sformatf("rr%0d latency", f), 32'(waited), 32'd0);
            step();
            check_frame($sformatf("rr%0d frame", f), (f % 2 == 1) ? 8'h22 : 8'h11);
        end
        v0 = 1'b0;
        v1 = 1'b0;

        // Lock held after last=0; in1 blocked until release.
        do_reset();
        v1 = 1'b1; b1 = 8'h7E; l1 = 1'b1;
        v0 = 1'b1; b0 = 8'h41; l0 = 1'b0;
        wait_grant(8, who, waited);
        chk("lock grant0", 32'(who), 32'd0);
        step();
        v0 = 1'b0;
        check_frame("lock 0x41 frame", 8'h41);
        step();
        first = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (k == 1) chk("lock busy", 32'(busy), 32'd1);
            if (rdy0 || rdy1) begin
                first = k;
                break;
            end
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        chk("timeout grant cycle", 32'(first), 32'd17);
        chk("timeout grant in1", 32'(rdy1), 32'd1);
        step();
        v1 = 1'b0;
        check_frame("timeout 0x7E frame", 8'h7E);
`else
        chk("no timeout grant", 32'(first), 32'd0);
        step();
        v0 = 1'b1; b0 = 8'h5A; l0 = 1'b1;
        wait_grant(8, who, waited);
        chk("lock grant0 again", 32'(who), 32'd0);
        step();
        v0 = 1'b0;
        check_frame("lock 0x5A frame", 8'h5A);
        wait_grant(8, who, waited);
        chk("unlock grant1", 32'(who), 32'd1);
        chk("unlock latency", 32'(waited), 32'd0);
        step();
        v1 = 1'b0;
        check_frame("unlock 0x7E frame", 8'h7E);
`endif
        step();
        @(negedge clock);
        chk("lock busy end", 32'(busy), 32'd0);

        // Reset in the middle of DATA.
        step();
        do_reset();
        v0 = 1'b1; b0 = 8'hF0; l0 = 1'b0;
        wait_grant(8, who, waited);
        chk("midrst grant", 32'(who), 32'd0);
        step();
        v0 = 1'b0;
        repeat (Cpb + 5) step();
        reset = 1'b1;
        step();
        @(negedge clock);
        chk("midrst tx", 32'(tx), 32'd1);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst owner", 32'(owner), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        v1 = 1'b1; b1 = 8'hA3; l1 = 1'b1;
        wait_grant(8, who, waited);
        chk("midrst regrant", 32'(who), 32'd1);
        step();
        v1 = 1'b0;
        check_frame("midrst 0xA3 frame", 8'hA3);
        step();
        @(negedge clock);
        chk("midrst busy end", 32'(busy), 32'd0);

        // Random traffic against a frame-level model.
        step();
        do_reset();
        m_free = 0; m_start = 0; m_to = 0;
        m_lock = 1'b0; m_owner = 1'b1; m_pend = 1'b0; m_byte = 8'h00;
        for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
            v0 = ($urandom_range(0, 9) < 4);
            v1 = ($urandom_range(0, 9) < 4);
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            l0 = ($urandom_range(0, 3) != 0);
            l1 = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            g  = -1;
            ov = m_owner ? v1 : v0;
            if (cyc >= m_free) begin
                if (m_lock) begin
                    if (ov) g = m_owner ? 1 : 0;
                end else if (v0 && v1) g = m_owner ? 0 : 1;
                else if (v0) g = 0;
                else if (v1) g = 1;
                e_r0   = (g == 0);
                e_r1   = (g == 1);
                e_tx   = 1'b1;
                e_busy = m_lock;
            end else begin
                e_r0   = 1'b0;
                e_r1   = 1'b0;
                e_tx   = frame_bit(m_byte, cyc - m_start);
                e_busy = 1'b1;
            end
            chk($sformatf("rand cyc%0d {r0,r1,tx,busy,owner}", cyc),
                32'({rdy0, rdy1, tx, busy, owner}),
                32'({e_r0, e_r1, e_tx, e_busy, m_owner}));
            if (cyc >= m_free) begin
                if (g >= 0) begin
                    m_owner = (g == 1);
                    m_byte  = (g == 1) ? b1 : b0;
                    m_pend  = (g == 1) ? !l1 : !l0;
                    m_start = cyc + 1;
                    m_free  = cyc + 1 + 10 * Cpb;
                    m_to    = 0;
                end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
                    if (m_lock && !ov) begin
                        m_to++;
                        if (m_to == To) begin
                            m_lock = 1'b0;
                            m_to   = 0;
                        end
                    end else m_to = 0;
`else
                    m_to = 0;
`endif
                end
            end else begin
                m_to = 0;
                if (cyc == m_free - 1) m_lock = m_pend;
            end
            @(posedge clock);
            #1;
        end
        v0 = 1'b0;
        v1 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit time; legal range 4..65535.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, idle cycles before a held lock is released; used only when the Configuration macro is defined.
REQ-003 SHALL have port clock, input, 1, single system clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have ports io_in0_valid / io_in1_valid, input, 1 each, requester n has a byte to send.
REQ-006 SHALL have ports io_in0_bits / io_in1_bits, input, 8 each, byte from requester n.
REQ-007 SHALL have ports io_in0_last / io_in1_last, input, 1 each, byte ends requester n's message.
REQ-008 SHALL have ports io_in0_ready / io_in1_ready, output, 1 each, one-cycle byte-accept strobe to requester n.
REQ-009 SHALL have port io_uart_tx, output, 1, serial line, 8N1, idle high.
REQ-010 SHALL have port io_busy, output, 1, high whenever FSM is not IDLE or a lock is held.
REQ-011 SHALL have port io_owner, output, 1, index of current or last granted requester.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-013 In IDLE with no lock, SHALL grant a valid requester; if both are valid, SHALL grant the one not equal to io_owner (round-robin); if only one is valid, SHALL grant it.
REQ-014 In IDLE with a lock held, SHALL consider only the locked owner; the other requester's valid SHALL be ignored.
REQ-015 On grant, SHALL assert the granted io_inN_ready for exactly one cycle, latch bits and last, set io_owner, and move to START next cycle.
REQ-016 A byte transfers only in a cycle with valid and ready both high; ready SHALL never be asserted in START, DATA or STOP.
REQ-017 START SHALL drive io_uart_tx low for CLKS_PER_BIT cycles, starting the cycle after acceptance.
REQ-018 DATA SHALL drive 8 bits LSB first, each for CLKS_PER_BIT cycles.
REQ-019 STOP SHALL drive io_uart_tx high for CLKS_PER_BIT cycles, then return to IDLE.
REQ-020 A full frame SHALL occupy exactly 10 x CLKS_PER_BIT cycles; a back-to-back byte may be accepted in the first IDLE cycle after STOP.
REQ-021 After sending a byte with last=0, SHALL set the lock to the owner; after a byte with last=1, SHALL clear the lock.
REQ-022 The bit counter (0..7) and baud counter (16 bits) SHALL wrap to 0 at each bit or frame boundary, with no off-by-one.
REQ-023 If valid deasserts while not ready, SHALL take no action; the requester is not required to hold valid.
REQ-024 io_uart_tx SHALL be 1 in IDLE.

Reset
REQ-025 On reset, state SHALL be IDLE, io_uart_tx=1, both ready=0, io_busy=0, io_owner=1 so that requester 0 wins the first tie, lock clear, and all counters 0.
REQ-026 Reset mid-frame SHALL abort the frame and drive io_uart_tx=1 in the next cycle; the partial byte is lost.

Configuration
REQ-027 With UART_TX_ARB_TIMEOUT_EN defined: SHALL clear the lock when in IDLE with the lock held and the owner's valid low for TIMEOUT_CYCLES consecutive cycles; the counter SHALL reset on owner valid or on leaving IDLE.
REQ-028 Without UART_TX_ARB_TIMEOUT_EN: the lock SHALL be held until a last=1 byte is sent, with no timeout logic synthesised.

Verification
REQ-029 Reset, then single byte 0x55 from in0 with last=1 (CLKS_PER_BIT=4) -> tx waveform low,1,0,1,0,1,0,1,0,high over 40 cycles; ready0 pulses once; lock clear at end.
REQ-030 in0 and in1 valid in the same cycle after reset -> in0 granted first; with both held, in1 granted next, alternating per message.
REQ-031 in0 sends 0x41 last=0 while in1 is continuously valid -> in1 not granted until in0 sends a last=1 byte; no interleaved bytes on tx.
REQ-032 Reset asserted in the middle of DATA -> tx=1 next cycle, busy=0, a new byte is accepted normally afterwards.
REQ-033 Macro defined, TIMEOUT_CYCLES=16: in0 sends last=0 then drops valid, in1 valid -> lock released after 16 idle cycles and in1 granted; macro undefined -> in1 never granted.
